// File: rtl/param_logic_cluster.sv
// rtl/param_logic_cluster.sv - NUM_LC-cell LUT/arith logic cluster with serial scan configuration
// Define SLC_SHADOW_CFG_EN to build a shadow config register committed by CFG_LOAD.
module param_logic_cluster #(
   parameter int NUM_LC = 8
) (
   input  logic                  QCK,
   input  logic                  QRTN,
   input  logic [4*NUM_LC-1:0]   LI,
   input  logic                  CI,
   input  logic                  QEN,
   input  logic                  QST,
   input  logic                  CFG_EN,
   input  logic                  CFG_DI,
   input  logic                  CFG_LOAD,
   output logic                  CFG_DO,
   output logic                  CFG_VLD,
   output logic [NUM_LC-1:0]     FZ,
   output logic [NUM_LC-1:0]     AQZ,
   output logic [NUM_LC-1:0]     BQZ,
   output logic [NUM_LC-1:0]     CQZ,
   output logic                  CO
);

   localparam int CFG_PER = 20;
   localparam int CFG_W   = NUM_LC * CFG_PER;
   localparam int CNT_W   = $clog2(CFG_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

   logic [CFG_W-1:0]  shift_reg;
   logic [CFG_W-1:0]  cfg;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              cfg_vld;

   logic [NUM_LC:0]   carry;
   logic [NUM_LC-1:0] fz;
   logic [NUM_LC-1:0] co;
   logic [NUM_LC-1:0] d;
   logic [NUM_LC-1:0] q;

   // The MSB of the chain is the last bit of the last cell, so the first bit shifted lands there.
   always_ff @(posedge QCK or negedge QRTN) begin
      if (!QRTN) begin
         shift_reg <= '0;
      end else if (CFG_EN) begin
         shift_reg <= {shift_reg[CFG_W-2:0], CFG_DI};
      end
   end

   always_comb begin
      cnt_nxt = cnt;
      if (CFG_EN && (cnt != CNT_MAX)) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge QCK or negedge QRTN) begin
      if (!QRTN) begin
         cnt     <= '0;
         cfg_vld <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         cfg_vld <= (cnt_nxt == CNT_MAX);
      end
   end

   assign CFG_DO  = shift_reg[CFG_W-1];
   assign CFG_VLD = cfg_vld;

`ifdef SLC_SHADOW_CFG_EN
   logic [CFG_W-1:0] active_cfg;

   // Non-blocking capture means a load coincident with a shift commits the pre-shift contents.
   always_ff @(posedge QCK or negedge QRTN) begin
      if (!QRTN) begin
         active_cfg <= '0;
      end else if (CFG_LOAD) begin
         active_cfg <= shift_reg;
      end
   end

   assign cfg = active_cfg;
`else
   logic unused_cfg_load;

   assign unused_cfg_load = CFG_LOAD;
   assign cfg             = shift_reg;
`endif

   assign carry[0] = CI;

   for (genvar k = 0; k < NUM_LC; k++) begin : g_cell
      logic [CFG_PER-1:0] word;
      logic [15:0]        lut;
      logic [3:0]         li;
      logic               maj;

      assign word = cfg[CFG_PER*k +: CFG_PER];
      assign lut  = word[15:0];
      assign li   = LI[4*k +: 4];
      assign maj  = (li[0] & li[1]) | (li[0] & carry[k]) | (li[1] & carry[k]);

      // In LUT mode the carry simply ripples through the cell.
      assign fz[k]      = word[16] ? (li[0] ^ li[1] ^ carry[k]) : lut[li];
      assign co[k]      = word[16] ? maj : carry[k];
      assign carry[k+1] = co[k];
      assign d[k]       = word[17] ? li[3] : fz[k];
      assign BQZ[k]     = word[18] ? fz[k] : q[k];
      assign CQZ[k]     = word[19] ? co[k] : q[k];
   end

   // Config shifting freezes the user flops ahead of set and enable.
   always_ff @(posedge QCK or negedge QRTN) begin
      if (!QRTN) begin
         q <= '0;
      end else if (CFG_EN) begin
         q <= q;
      end else if (QST) begin
         q <= '1;
      end else if (QEN) begin
         q <= d;
      end
   end

   assign FZ  = fz;
   assign AQZ = q;
   assign CO  = carry[NUM_LC];

endmodule

// File: tb/tb_param_logic_cluster.sv
// tb/tb_param_logic_cluster.sv - scoreboard bench for param_logic_cluster
module tb_param_logic_cluster;

   localparam int NUM_LC = 8;
   localparam int CFG_W  = NUM_LC * 20;

   logic                QCK = 1'b0;
   logic                QRTN;
   logic [4*NUM_LC-1:0] LI;
   logic                CI;
   logic                QEN;
   logic                QST;
   logic                CFG_EN;
   logic                CFG_DI;
   logic                CFG_LOAD;
   logic                CFG_DO;
   logic                CFG_VLD;
   logic [NUM_LC-1:0]   FZ;
   logic [NUM_LC-1:0]   AQZ;
   logic [NUM_LC-1:0]   BQZ;
   logic [NUM_LC-1:0]   CQZ;
   logic                CO;

   always #5 QCK = ~QCK;

   param_logic_cluster #(.NUM_LC(NUM_LC)) dut (
      .QCK(QCK), .QRTN(QRTN), .LI(LI), .CI(CI), .QEN(QEN), .QST(QST),
      .CFG_EN(CFG_EN), .CFG_DI(CFG_DI), .CFG_LOAD(CFG_LOAD), .CFG_DO(CFG_DO),
      .CFG_VLD(CFG_VLD), .FZ(FZ), .AQZ(AQZ), .BQZ(BQZ), .CQZ(CQZ), .CO(CO)
   );

   typedef enum int {S_FZ, S_AQZ, S_BQZ, S_CQZ, S_CO, S_VLD, S_DO} sel_t;
   typedef struct {
      string       name;
      sel_t        sel;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [31:0] observe(sel_t s);
      case (s)
         S_FZ:    return 32'(FZ);
         S_AQZ:   return 32'(AQZ);
         S_BQZ:   return 32'(BQZ);
         S_CQZ:   return 32'(CQZ);
         S_CO:    return 32'(CO);
         S_VLD:   return 32'(CFG_VLD);
         default: return 32'(CFG_DO);
      endcase
   endfunction

   always @(negedge QCK) begin : monitor
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (observe(e.sel) !== e.val) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", e.name, observe(e.sel), e.val);
         end
      end
   end

   task automatic expect_out(input string name, input sel_t s, input logic [31:0] v);
      exp_q.push_back('{name, s, v});
   endtask

   task automatic drain();
      @(negedge QCK);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic clk_ff(input logic qen, input logic qst, input logic cen);
      QEN = qen; QST = qst; CFG_EN = cen;
      @(posedge QCK);
      #1;
      QEN = 1'b0; QST = 1'b0; CFG_EN = 1'b0;
   endtask

   task automatic shift1(input logic b);
      CFG_DI = b;
      clk_ff(1'b0, 1'b0, 1'b1);
   endtask

   task automatic shift_only(input logic [CFG_W-1:0] c);
      CFG_EN = 1'b1;
      for (int i = CFG_W - 1; i >= 0; i--) begin
         CFG_DI = c[i];
         @(posedge QCK);
         #1;
      end
      CFG_EN = 1'b0;
   endtask

   task automatic pulse_load();
      CFG_LOAD = 1'b1;
      @(posedge QCK);
      #1;
      CFG_LOAD = 1'b0;
   endtask

   task automatic load_cfg(input logic [CFG_W-1:0] c);
      shift_only(c);
      pulse_load();
   endtask

   task automatic set_ab(input logic [7:0] a, input logic [7:0] b);
      LI = '0;
      for (int k = 0; k < NUM_LC; k++) begin
         LI[4*k]   = a[k];
         LI[4*k+1] = b[k];
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [CFG_W-1:0] cfg_v;
      logic [7:0]       pat;
      int               n;

      QRTN = 1'b0; CI = 1'b1; LI = '0; QEN = 1'b0; QST = 1'b0;
      CFG_EN = 1'b0; CFG_DI = 1'b0; CFG_LOAD = 1'b0;
      #2;
      expect_out("rst_fz",  S_FZ,  32'h0);
      expect_out("rst_aqz", S_AQZ, 32'h0);
      expect_out("rst_bqz", S_BQZ, 32'h0);
      expect_out("rst_cqz", S_CQZ, 32'h0);
      expect_out("rst_vld", S_VLD, 32'h0);
      expect_out("rst_do",  S_DO,  32'h0);
      expect_out("rst_co",  S_CO,  32'h1);
      drain();

      // Partial shift of ones, then asynchronous reset mid-shift.
      QRTN = 1'b1;
      CFG_EN = 1'b1; CFG_DI = 1'b1;
      repeat (50) begin
         @(posedge QCK);
         #1;
      end
      QRTN = 1'b0;
      CFG_EN = 1'b0;
      expect_out("midrst_fz",  S_FZ,  32'h0);
      expect_out("midrst_aqz", S_AQZ, 32'h0);
      expect_out("midrst_vld", S_VLD, 32'h0);
      expect_out("midrst_co",  S_CO,  32'h1);
      drain();
      QRTN = 1'b1;
      for (int i = 0; i < CFG_W - 1; i++) shift1(1'b0);
      expect_out("vld_before_full", S_VLD, 32'h0);
      drain();
      shift1(1'b0);
      expect_out("vld_at_full", S_VLD, 32'h1);
      drain();
      shift1(1'b0);
      expect_out("vld_after_extra", S_VLD, 32'h1);
      drain();

      // Cell 0 AND4, cell 1 bypasses LI[7] into its flop.
      CI = 1'b0;
      cfg_v = '0;
      cfg_v[15:0] = 16'h8000;
      cfg_v[20+17] = 1'b1;
      load_cfg(cfg_v);
      LI = '0; LI[3:0] = 4'hF; LI[7] = 1'b1;
      expect_out("and4_fz_f", S_FZ, 32'h01);
      drain();
      clk_ff(1'b1, 1'b0, 1'b0);
      expect_out("and4_aqz", S_AQZ, 32'h03);
      expect_out("and4_bqz", S_BQZ, 32'h03);
      drain();
      LI[3:0] = 4'hE;
      expect_out("and4_fz_e", S_FZ, 32'h00);
      expect_out("and4_aqz_hold", S_AQZ, 32'h03);
      drain();

      // Flop priority.
      CFG_DI = 1'b0;
      clk_ff(1'b1, 1'b1, 1'b1);
      expect_out("cfgen_beats_qst", S_AQZ, 32'h03);
      drain();
      load_cfg(cfg_v);
      expect_out("frozen_during_load", S_AQZ, 32'h03);
      drain();
      clk_ff(1'b1, 1'b1, 1'b0);
      expect_out("qst_beats_qen", S_AQZ, 32'hFF);
      drain();
      LI[7] = 1'b0;
      clk_ff(1'b1, 1'b0, 1'b0);
      expect_out("qen_loads_d", S_AQZ, 32'h00);
      drain();
      clk_ff(1'b0, 1'b1, 1'b0);
      expect_out("qst_alone", S_AQZ, 32'hFF);
      drain();
      clk_ff(1'b0, 1'b0, 1'b0);
      expect_out("idle_hold", S_AQZ, 32'hFF);
      drain();

      // Ripple adder: every cell ARITH with BQZ_SEL and CQZ_SEL.
      for (int k = 0; k < NUM_LC; k++) cfg_v[20*k +: 20] = 20'hD0000;
      load_cfg(cfg_v);
      CI = 1'b0; set_ab(8'hFF, 8'h01);
      expect_out("add_ff01_fz",  S_FZ,  32'h00);
      expect_out("add_ff01_co",  S_CO,  32'h1);
      expect_out("add_ff01_cqz", S_CQZ, 32'hFF);
      expect_out("add_ff01_bqz", S_BQZ, 32'h00);
      drain();
      set_ab(8'h0F, 8'h01);
      expect_out("add_0f01_fz",  S_FZ,  32'h10);
      expect_out("add_0f01_co",  S_CO,  32'h0);
      expect_out("add_0f01_cqz", S_CQZ, 32'h0F);
      drain();
      CI = 1'b1; set_ab(8'h12, 8'h34);
      expect_out("add_1234c_fz",  S_FZ,  32'h47);
      expect_out("add_1234c_co",  S_CO,  32'h0);
      expect_out("add_1234c_cqz", S_CQZ, 32'h30);
      expect_out("add_1234c_bqz", S_BQZ, 32'h47);
      drain();
      set_ab(8'hFF, 8'h00);
      expect_out("add_ff00c_fz", S_FZ, 32'h00);
      expect_out("add_ff00c_co", S_CO, 32'h1);
      drain();
      CI = 1'b0;

`ifdef SLC_SHADOW_CFG_EN
      cfg_v = '0;
      cfg_v[15:0] = 16'h8000;
      load_cfg(cfg_v);
      LI = '0; LI[3:0] = 4'hF;
      expect_out("shadow_and4_f", S_FZ, 32'h01);
      drain();
      cfg_v[15:0] = 16'hFFFE;
      shift_only(cfg_v);
      LI[3:0] = 4'hE;
      expect_out("shadow_still_and4", S_FZ, 32'h00);
      drain();
      pulse_load();
      expect_out("shadow_or4_loaded", S_FZ, 32'h01);
      drain();
`else
      load_cfg('0);
      LI = '0;
      expect_out("direct_zero", S_FZ, 32'h00);
      drain();
      shift1(1'b1);
      expect_out("direct_bit0_live", S_FZ, 32'h01);
      drain();
      shift1(1'b0);
      expect_out("direct_bit1_li0", S_FZ, 32'h00);
      drain();
      LI[0] = 1'b1;
      expect_out("direct_bit1_li1", S_FZ, 32'h01);
      drain();
`endif

      // Readback: CFG_DO replays the pattern CFG_W shifts later.
      pat = 8'hA5;
      CFG_EN = 1'b1;
      for (int i = 0; i < 2 * CFG_W; i++) begin
         CFG_DI = pat[7 - (i % 8)];
         @(posedge QCK);
         #1;
         n = i + 1 - CFG_W;
         if (n >= 0) begin
            expect_out("readback_do", S_DO, 32'(pat[7 - (n % 8)]));
            drain();
         end
      end
      CFG_EN = 1'b0;
      expect_out("readback_vld", S_VLD, 32'h1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
